// File: rtl/l2d_rx.sv
// Two-line serial link receiver: synchronizes an async sclk/CS/DL0/DL1 link and assembles 64-bit
// frames for a valid/ready consumer. Define L2D_FRAME_ERR_EN to add the FRAME_ERR pulse output.
module l2d_rx (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sclk,
  input  logic        CS,
  input  logic        DL0,
  input  logic        DL1,
  output logic [63:0] DATA_OUT,
  output logic        VALID,
  input  logic        READY,
  output logic        DONE,
  output logic        OVERRUN
`ifdef L2D_FRAME_ERR_EN
  ,
  output logic        FRAME_ERR
`endif
);

  typedef enum logic [1:0] {StIdle, StRecv, StDiscard} state_e;

  localparam logic [5:0] FullCount = 6'd32;
  localparam logic [5:0] OverCount = 6'd33;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] shift_q, shift_d;

  logic [2:0]  sclk_sync_q;
  logic [2:0]  cs_sync_q;
  logic [1:0]  dl0_sync_q;
  logic [1:0]  dl1_sync_q;
  logic [1:0]  flush_q;
  logic        armed_q;

  logic        sclk_rise;
  logic        cs_rise;
  logic        cs_fall;
  logic        frame_good;

  logic [63:0] data_d;
  logic        valid_d;
  logic        overrun_d;

  // CS resets to its idle-high level so a link that is idle at reset release shows no edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      dl0_sync_q  <= 2'b00;
      dl1_sync_q  <= 2'b00;
      flush_q     <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], CS};
      dl0_sync_q  <= {dl0_sync_q[0], DL0};
      dl1_sync_q  <= {dl1_sync_q[0], DL1};
      flush_q     <= {flush_q[0], 1'b1};
      armed_q     <= armed_q | (flush_q[1] & cs_sync_q[1]);
    end
  end

  // A frame only starts after CS has really been seen high since reset, so a reset released
  // mid-frame drops that partial frame instead of mistaking the reset value for a CS fall.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2] & armed_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    frame_good = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StRecv;
          cnt_d   = '0;
        end
      end
      StRecv: begin
        if (cs_rise) begin
          state_d    = StIdle;
          frame_good = (cnt_q == FullCount);
        end else if (sclk_rise) begin
          shift_d = {shift_q[61:0], dl1_sync_q[1], dl0_sync_q[1]};
          if (cnt_q == FullCount) begin
            state_d = StDiscard;
            cnt_d   = OverCount;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      StDiscard: begin
        if (cs_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d    = DATA_OUT;
    valid_d   = VALID;
    overrun_d = OVERRUN;
    if (frame_good) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (VALID && !READY) begin
        overrun_d = 1'b1;
      end
    end else if (VALID && READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      DATA_OUT <= '0;
      VALID    <= 1'b0;
      DONE     <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      DATA_OUT <= data_d;
      VALID    <= valid_d;
      DONE     <= frame_good;
      OVERRUN  <= overrun_d;
    end
  end

`ifdef L2D_FRAME_ERR_EN
  logic frame_bad;

  assign frame_bad = cs_rise & (((state_q == StRecv) && (cnt_q != FullCount)) ||
                                (state_q == StDiscard));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= frame_bad;
    end
  end
`endif

endmodule

// File: tb/tb_l2d_rx.sv
// Bench for l2d_rx: frame-level reference model (pair counts, word, completion edge) checked
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_l2d_rx;

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        sclk  = 1'b0;
  logic        CS    = 1'b1;
  logic        DL0   = 1'b0;
  logic        DL1   = 1'b0;
  logic        READY = 1'b0;
  logic [63:0] DATA_OUT;
  logic        VALID;
  logic        DONE;
  logic        OVERRUN;
`ifdef L2D_FRAME_ERR_EN
  logic        FRAME_ERR;
`endif

  l2d_rx dut (
    .clk      (clk),
    .rstn     (rstn),
    .sclk     (sclk),
    .CS       (CS),
    .DL0      (DL0),
    .DL1      (DL1),
    .DATA_OUT (DATA_OUT),
    .VALID    (VALID),
    .READY    (READY),
    .DONE     (DONE),
    .OVERRUN  (OVERRUN)
`ifdef L2D_FRAME_ERR_EN
    ,
    .FRAME_ERR(FRAME_ERR)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    bit          good;
    logic [63:0] w;
  } ev_t;

  ev_t         evq[$];
  ev_t         cur;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          en = 0;
  int          ready_mode = 0;
  int          pulse_edge = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;
  int          ferr_cnt = 0;
  logic [63:0] m_data = '0;
  bit          m_valid = 0;
  bit          m_done = 0;
  bit          m_over = 0;
  bit          m_ferr = 0;
  bit          m_good;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each completed frame is an event at a known edge; good frames load the
  // word, bad ones only raise the frame-error pulse. Consumer handshake follows READY.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data  = '0;
      m_valid = 0;
      m_done  = 0;
      m_over  = 0;
      m_ferr  = 0;
      evq.delete();
    end else begin
      m_good = 0;
      m_done = 0;
      m_ferr = 0;
      if (evq.size() > 0 && evq[0].edge_n == cyc + 1) begin
        cur = evq.pop_front();
        if (cur.good) m_good = 1;
        else          m_ferr = 1;
      end
      if (m_good) begin
        if (m_valid && !READY) m_over = 1;
        m_data  = cur.w;
        m_valid = 1;
        m_done  = 1;
      end else if (m_valid && READY) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("data_out", DATA_OUT, m_data);
      chk("valid", 64'(VALID), 64'(m_valid));
      chk("done", 64'(DONE), 64'(m_done));
      chk("overrun", 64'(OVERRUN), 64'(m_over));
      if (DONE) done_cnt++;
      if (VALID) valid_cnt++;
`ifdef L2D_FRAME_ERR_EN
      chk("frame_err", 64'(FRAME_ERR), 64'(m_ferr));
      if (FRAME_ERR) ferr_cnt++;
`endif
    end
  end

  always @(negedge clk) begin
    case (ready_mode)
      0:       READY = 1'b0;
      1:       READY = 1'b1;
      2:       READY = 1'($urandom_range(0, 1));
      default: READY = (cyc + 1 == pulse_edge);
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pairs(input logic [63:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      if (i < 32) begin
        DL1 = w[63-2*i];
        DL0 = w[62-2*i];
      end else begin
        DL1 = 1'($urandom_range(0, 1));
        DL0 = 1'($urandom_range(0, 1));
      end
      tick($urandom_range(4, 6));
      sclk = 1'b1;
      tick($urandom_range(4, 6));
      sclk = 1'b0;
    end
  endtask

  // CS is sampled by the first synchronizer at edge cyc+1; the result lands on edge cyc+3.
  task automatic end_frame(input bit push, input bit good, input logic [63:0] w);
    ev_t e;
    CS = 1'b1;
    pulse_edge = cyc + 3;
    if (push) begin
      e.edge_n = cyc + 3;
      e.good   = good;
      e.w      = w;
      evq.push_back(e);
    end
    tick(8);
  endtask

  task automatic frame(input logic [63:0] w, input int n);
    CS = 1'b0;
    tick(3);
    send_pairs(w, 0, n);
    tick(4);
    end_frame(1, n == 32, w);
  endtask

  task automatic short_pulse();
    CS = 1'b0;
    tick(1);
    end_frame(1, 0, '0);
  endtask

  int          d0, v0, f0, n;
  logic [63:0] w;

  initial begin
    tick(3);
    en = 1;
    chk("rst_data", DATA_OUT, 64'h0);
    chk("rst_valid", 64'(VALID), 64'h0);
    chk("rst_overrun", 64'(OVERRUN), 64'h0);
    tick(2);
    rstn = 1'b1;
    tick(6);

    // Single frame, consumer always ready.
    ready_mode = 1;
    d0 = done_cnt; v0 = valid_cnt;
    frame(64'hDEADBEEF_01234567, 32);
    chk("deadbeef_data", DATA_OUT, 64'hDEADBEEF_01234567);
    chk("deadbeef_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("deadbeef_valid_cycles", 64'(valid_cnt - v0), 64'd1);

    // READY pulsed on the very edge a new word lands.
    ready_mode = 0;
    frame(64'h1111_2222_3333_4444, 32);
    chk("hold_valid", 64'(VALID), 64'd1);
    ready_mode = 3;
    frame(64'h5555_6666_7777_8888, 32);
    chk("sameedge_data", DATA_OUT, 64'h5555_6666_7777_8888);
    chk("sameedge_valid", 64'(VALID), 64'd1);
    chk("sameedge_overrun", 64'(OVERRUN), 64'd0);

    // Two words with no consumer: overrun.
    ready_mode = 0;
    d0 = done_cnt;
    frame(64'h1, 32);
    frame(64'h2, 32);
    chk("overrun_data", DATA_OUT, 64'h2);
    chk("overrun_valid", 64'(VALID), 64'd1);
    chk("overrun_flag", 64'(OVERRUN), 64'd1);
    chk("overrun_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Short frames: 31 pairs, then a one-cycle CS pulse.
    d0 = done_cnt; f0 = ferr_cnt;
    frame(64'hFFFF_FFFF_FFFF_FFFF, 31);
    chk("short_done_pulses", 64'(done_cnt - d0), 64'd0);
    chk("short_valid", 64'(VALID), 64'd1);
    chk("short_data", DATA_OUT, 64'h2);
`ifdef L2D_FRAME_ERR_EN
    chk("short_frame_err", 64'(ferr_cnt - f0), 64'd1);
`endif
    d0 = done_cnt;
    short_pulse();
    chk("pulse_done_pulses", 64'(done_cnt - d0), 64'd0);

    // Long frame discarded, then a good frame.
    ready_mode = 1;
    d0 = done_cnt; f0 = ferr_cnt;
    frame(64'h0123_4567_89AB_CDEF, 34);
    chk("long_done_pulses", 64'(done_cnt - d0), 64'd0);
`ifdef L2D_FRAME_ERR_EN
    chk("long_frame_err", 64'(ferr_cnt - f0), 64'd1);
`endif
    frame(64'hA5A5A5A5_A5A5A5A5, 32);
    chk("after_long_data", DATA_OUT, 64'hA5A5A5A5_A5A5A5A5);
    chk("after_long_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Reset mid-frame, released with CS still low.
    d0 = done_cnt;
    w = 64'hCAFE_F00D_1234_5678;
    CS = 1'b0;
    tick(3);
    send_pairs(w, 0, 10);
    rstn = 1'b0;
    tick(2);
    chk("midrst_data", DATA_OUT, 64'h0);
    chk("midrst_valid", 64'(VALID), 64'd0);
    chk("midrst_overrun", 64'(OVERRUN), 64'd0);
    chk("midrst_done", 64'(DONE), 64'd0);
    rstn = 1'b1;
    tick(3);
    send_pairs(w, 10, 22);
    tick(4);
    end_frame(0, 0, '0);
    chk("dropped_done_pulses", 64'(done_cnt - d0), 64'd0);
    chk("dropped_data", DATA_OUT, 64'h0);
    frame(64'h0F1E2D3C_4B5A6978, 32);
    chk("post_rst_data", DATA_OUT, 64'h0F1E2D3C_4B5A6978);
    chk("post_rst_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Randomized frames and consumer backpressure.
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      w = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       n = 31;
        1:       n = 33;
        2:       n = $urandom_range(0, 5);
        3:       n = $urandom_range(34, 36);
        default: n = 32;
      endcase
      if ($urandom_range(0, 15) == 0) short_pulse();
      else                            frame(w, n);
      tick($urandom_range(0, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2d_rx.md
L2D_RX -- requirements
Module: l2d_rx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port sclk, input, 1, external link clock, asynchronous to clk.
REQ-004 SHALL have port CS, input, 1, active-low frame select, asynchronous to clk.
REQ-005 SHALL have port DL0, input, 1, data line 0, asynchronous to clk.
REQ-006 SHALL have port DL1, input, 1, data line 1, asynchronous to clk.
REQ-007 SHALL have port DATA_OUT, output, 64, received word held in the output register.
REQ-008 SHALL have port VALID, output, 1, DATA_OUT holds an unconsumed word.
REQ-009 SHALL have port READY, input, 1, consumer accepts the word in any cycle where VALID and READY are both high.
REQ-010 SHALL have port DONE, output, 1, one-cycle pulse when a word loads into DATA_OUT.
REQ-011 SHALL have port OVERRUN, output, 1, sticky flag for a word lost because VALID was high and READY low.
REQ-012 SHALL have port FRAME_ERR, output, 1, one-cycle pulse on a malformed frame (present only under L2D_FRAME_ERR_EN).

Function
REQ-013 SHALL pass sclk, CS, DL0 and DL1 through 2-flop synchronizers, plus a third stage on sclk and CS for edge detection.
REQ-014 SHALL define a sclk rise as sync2=1 and sync3=0, and a CS rise (frame end) and CS fall (frame start) the same way on CS.
REQ-015 SHALL implement FSM IDLE -> RECV on CS fall; RECV -> IDLE on CS rise; RECV -> DISCARD when a 33rd pair arrives; DISCARD -> IDLE on CS rise.
REQ-016 SHALL, in RECV, on each sclk rise shift the 64-bit shift register left by 2 and insert {DL1,DL0} (synchronized) at bits [1:0], making the frame MSB first.
REQ-017 SHALL keep a 6-bit pair counter, cleared on entry to RECV and incremented per sclk rise, saturating at 33.
REQ-018 SHALL classify a frame as good only when CS rises with the pair count exactly 32.
REQ-019 SHALL, on a good frame: load DATA_OUT from the shift register, set VALID, and pulse DONE, all on the same edge.
REQ-020 SHALL give a latency of 3 clk edges from the first synchronizer stage capturing CS high to VALID/DONE high.
REQ-021 SHALL clear VALID on the edge where VALID and READY are both high.
REQ-022 SHALL, when a good frame completes while VALID=1 and READY=0: overwrite DATA_OUT, keep VALID=1, pulse DONE, and set OVERRUN.
REQ-023 SHALL, when a good frame completes in the same cycle as VALID&READY: load the new word and hold VALID=1, with no overrun.
REQ-024 SHALL leave DATA_OUT, VALID and DONE untouched on a short frame (count below 32) or a long frame (DISCARD).
REQ-025 SHALL ignore sclk rises while in IDLE or DISCARD.
REQ-026 SHALL treat a CS fall and rise within one cycle of each other as a frame with count 0, i.e. a short frame.
REQ-027 SHALL clear OVERRUN only by reset.
REQ-028 SHALL support a sclk high or low phase of at least 4 clk periods; data lines SHALL be stable from 1 clk period before to 3 after each sclk rise.

Reset
REQ-029 SHALL, on rstn low, immediately set: FSM=IDLE, counter=0, shift register=0, DATA_OUT=0, VALID=0, DONE=0, OVERRUN=0, FRAME_ERR=0.
REQ-030 SHALL reset synchronizers to sclk=0, CS=1 and DL0=DL1=0, so no spurious edge appears after reset.
REQ-031 SHALL, when rstn releases mid-frame (CS already low), stay in IDLE until a fresh CS fall; that partial frame SHALL be dropped.

Configuration
REQ-032 SHALL, with macro L2D_FRAME_ERR_EN defined, provide the FRAME_ERR port and pulse it for one cycle on CS rise with count other than 32, or on CS rise out of DISCARD.
REQ-033 SHALL, without L2D_FRAME_ERR_EN, omit the FRAME_ERR port and its logic, while malformed frames are still dropped silently per REQ-024.

Verification
REQ-034 SHALL cover: 32 pairs sending 64'hDEADBEEF_01234567, READY=1 -> DATA_OUT=64'hDEADBEEF_01234567, one DONE pulse, VALID high for 1 cycle.
REQ-035 SHALL cover: two good frames (64'h1, then 64'h2) with READY=0 -> DATA_OUT=64'h2, VALID=1, OVERRUN=1, two DONE pulses.
REQ-036 SHALL cover: a 31-pair frame -> no DONE, VALID unchanged, FRAME_ERR pulses once when the macro is defined.
REQ-037 SHALL cover: a 34-pair frame -> FSM enters DISCARD, no DONE, FRAME_ERR pulses once at CS rise; then a following good frame 64'hA5A5... is received correctly.
REQ-038 SHALL cover: rstn asserted after 10 pairs, released with CS low -> all outputs 0, the remaining pairs are ignored, and the next full frame is received.
REQ-039 SHALL cover: READY pulsed in the same cycle a new frame completes -> VALID stays 1, new word present, OVERRUN=0.
